shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Controller that sequences the 4-bit serial-in shift register datapath (shift-enable `shr`, serial input `shr_in`, parallel output).
- Accepts a parallel word over a valid/ready handshake and drives the register's shift enable and serial input bit by bit, with a programmable idle gap between shifts.
- After the last shift it captures the register's parallel output, compares it with the requested word, and pulses done.
- Sits between a host/test sequencer and the shift register instance.

Parameters:
W, 4, word width; equals shift register width and number of shifts per transfer.
GAP, 0, idle cycles (`shr`=0) inserted between consecutive shifts; 0..15.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_valid  input  1  host requests a transfer.
start_ready  output  1  controller can accept a transfer (high only in IDLE).
data_in  input  W  word to load into the shift register.
abort  input  1  cancel the transfer in progress.
shr  output  1  shift enable to the shift register.
shr_in  output  1  serial data to the shift register.
sr_q  input  W  parallel output of the shift register.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse: result and match are valid.
result  output  W  captured sr_q.
match  output  1  result == word latched at start.

Behaviour:
- Reset (async, any time, including mid-transfer): state=IDLE; shadow, word, bit counter, gap counter, result=0; done=0; match=0; shr=0; shr_in=0; busy=0; start_ready=1.
- Shift register semantics (fixed contract):
  - `shr`=1 at a rising edge shifts right.
  - `shr_in` enters bit W-1.
  - Data is therefore sent LSB first, so that after W shifts sr_q == data_in.
- `shr`, `shr_in`, `busy` and `start_ready` decode only from registered state, with no combinational path from inputs.
- States: IDLE, SHIFT, GAP, SETTLE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: latch word<=data_in and shadow<=data_in; bitcnt<=0; go to SHIFT.
  - start_valid while busy is ignored; no queueing.
- SHIFT:
  - shr=1; shr_in=shadow[0].
  - On the edge: shadow>>=1; bitcnt++.
  - If bitcnt==W-1, go to SETTLE.
  - Else if GAP>0, set gapcnt<=GAP-1 and go to GAP.
  - Else stay in SHIFT.
- GAP: shr=0; shr_in=0. Decrement gapcnt; at 0 go to SHIFT. No gap follows the final shift.
- SETTLE:
  - shr=0. sr_q is stable this cycle.
  - On the edge: result<=sr_q; match<=(sr_q==word); done<=1; go to IDLE.
- done is high exactly one cycle, the first IDLE cycle; start_ready is also high in that cycle.
  - A new start accepted there is legal.
  - result/match hold until the next done.
- Latency: the handshake edge is cycle 0.
  - Shifts occur in cycles 1, 1+(GAP+1), …, 1+(W-1)(GAP+1).
  - SETTLE follows the last shift; done is high 2 cycles after the last shift.
  - GAP=0, W=4: shr high in cycles 1–4, done in cycle 6.
- abort:
  - Sampled in SHIFT, GAP or SETTLE; on that edge go to IDLE with shr=0.
  - The shift in progress in an aborted SHIFT cycle still occurs externally, because shr was high.
  - No done; result/match unchanged.
  - abort in IDLE has no effect; abort has priority over start on the same edge only if not in IDLE.
- Simultaneous start_valid and a done cycle: accepted normally.

Test Plan:
- W=4, GAP=0, data_in=4'b1011, bench shift-register model attached →
  - shr=1 in cycles 1–4, shr_in sequence 1,1,0,1.
  - done in cycle 6 with result=4'b1011, match=1.
  - busy high in cycles 1–5.
- GAP=2, data_in=4'b0110 →
  - shr high only in cycles 1, 4, 7, 10, shr_in 0,1,1,0.
  - done in cycle 12, result=4'b0110, match=1.
- Model with bit 2 stuck at 0, data_in=4'b0100 → done with result=4'b0000, match=0.
- Back-to-back: start_valid held high continuously with data 4'b1111 then 4'b0001 →
  - second transfer accepted in the done cycle, start_ready=0 during the first.
  - two done pulses, results 4'b1111 then 4'b0001.
- abort asserted in cycle 2 of a GAP=0 transfer → IDLE in cycle 3, shr=0, no done, previous result/match unchanged.
- rst pulsed (mid-cycle, asynchronous) during GAP → outputs return to reset values immediately; a fresh transfer afterwards completes with match=1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequencer that serially loads a W-bit shift register and checks the result
module shift_seq_ctrl #(
  parameter int W   = 4,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] data_in,
  input  logic         abort,
  output logic         shr,
  output logic         shr_in,
  input  logic [W-1:0] sr_q,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         match
);

  localparam int             BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(W - 1);
  // Gap counter counts GAP-1 down to 0, so the GAP state lasts exactly GAP cycles.
  localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_SETTLE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_shadow;
  logic [W-1:0]   r_word;
  logic [BW-1:0]  r_bitcnt;
  logic [3:0]     r_gapcnt;
  logic [W-1:0]   r_result;
  logic           r_match;
  logic           r_done;

  state_t         w_state_nxt;
  logic [W-1:0]   w_shadow_nxt;
  logic [W-1:0]   w_word_nxt;
  logic [BW-1:0]  w_bitcnt_nxt;
  logic [3:0]     w_gapcnt_nxt;
  logic [W-1:0]   w_result_nxt;
  logic           w_match_nxt;
  logic           w_done_nxt;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_word   <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_result <= '0;
      r_match  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_word   <= w_word_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
      r_result <= w_result_nxt;
      r_match  <= w_match_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and datapath update; abort wins over everything outside IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_word_nxt   = r_word;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    w_result_nxt = r_result;
    w_match_nxt  = r_match;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_word_nxt   = data_in;
          w_shadow_nxt = data_in;
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          // LSB leaves first; it lands in bit 0 of the register after W shifts.
          w_shadow_nxt = {1'b0, r_shadow[W-1:1]};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == LAST_BIT) begin
            w_state_nxt = S_SETTLE;
          end else if (GAP > 0) begin
            w_gapcnt_nxt = GAP_LOAD;
            w_state_nxt  = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_gapcnt == 4'd0) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_gapcnt_nxt = r_gapcnt - 4'd1;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_result_nxt = sr_q;
          w_match_nxt  = (sr_q == r_word);
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift-register controls and handshake decode purely from registered state.
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    shr         = 1'b0;
    shr_in      = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_SHIFT: begin
        shr    = 1'b1;
        shr_in = r_shadow[0];
      end
      default: begin
        shr    = 1'b0;
        shr_in = 1'b0;
      end
    endcase
  end

  assign done   = r_done;
  assign result = r_result;
  assign match  = r_match;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;

  logic       sv0, ab0, ready0, shr0, shin0, busy0, done0, match0;
  logic [3:0] din0, srq0, res0;
  logic       sv2, ab2, ready2, shr2, shin2, busy2, done2, match2;
  logic [3:0] din2, srq2, res2;

  logic       stuck0;
  logic [3:0] sr0, sr2;

  int n_cmp = 0;
  int n_err = 0;

  shift_seq_ctrl #(.W(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(ready0), .data_in(din0),
    .abort(ab0), .shr(shr0), .shr_in(shin0), .sr_q(srq0), .busy(busy0),
    .done(done0), .result(res0), .match(match0)
  );

  shift_seq_ctrl #(.W(4), .GAP(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(ready2), .data_in(din2),
    .abort(ab2), .shr(shr2), .shr_in(shin2), .sr_q(srq2), .busy(busy2),
    .done(done2), .result(res2), .match(match2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-register models: right shift, serial bit enters bit 3; optional bit 2 stuck at 0.
  always @(posedge clk or posedge rst) begin
    if (rst) sr0 <= 4'b0000;
    else if (shr0) sr0 <= {shin0, sr0[3:1]} & (stuck0 ? 4'b1011 : 4'b1111);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) sr2 <= 4'b0000;
    else if (shr2) sr2 <= {shin2, sr2[3:1]};
  end
  assign srq0 = sr0;
  assign srq2 = sr2;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // GAP=0 transfer: shifts in cycles 1..4, SETTLE in 5, done in 6.
  task automatic run0(input logic [3:0] d, input logic [3:0] exp_res, input logic exp_m, input string tag);
    logic sh;
    sv0  = 1'b1;
    din0 = d;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) sv0 = 1'b0;
      sh = (c <= 4);
      chk1($sformatf("%s c%0d shr", tag, c), shr0, sh);
      chk1($sformatf("%s c%0d shr_in", tag, c), shin0, sh ? d[c-1] : 1'b0);
      chk1($sformatf("%s c%0d busy", tag, c), busy0, (c <= 5));
      chk1($sformatf("%s c%0d ready", tag, c), ready0, (c >= 6));
      chk1($sformatf("%s c%0d done", tag, c), done0, (c == 6));
      if (c >= 6) begin
        chk4($sformatf("%s c%0d result", tag, c), res0, exp_res);
        chk1($sformatf("%s c%0d match", tag, c), match0, exp_m);
      end
    end
  endtask

  // GAP=2 transfer: shifts in cycles 1,4,7,10, SETTLE in 11, done in 12.
  task automatic run2(input logic [3:0] d, input logic [3:0] exp_res, input logic exp_m, input string tag);
    logic sh;
    sv2  = 1'b1;
    din2 = d;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 1) sv2 = 1'b0;
      sh = (c <= 10) && ((c - 1) % 3 == 0);
      chk1($sformatf("%s c%0d shr", tag, c), shr2, sh);
      chk1($sformatf("%s c%0d shr_in", tag, c), shin2, sh ? d[(c-1)/3] : 1'b0);
      chk1($sformatf("%s c%0d busy", tag, c), busy2, (c <= 11));
      chk1($sformatf("%s c%0d done", tag, c), done2, (c == 12));
      if (c >= 12) begin
        chk4($sformatf("%s c%0d result", tag, c), res2, exp_res);
        chk1($sformatf("%s c%0d match", tag, c), match2, exp_m);
      end
    end
  endtask

  initial begin
    int ndone;
    rst = 1'b1; stuck0 = 1'b0;
    sv0 = 1'b0; ab0 = 1'b0; din0 = 4'b0000;
    sv2 = 1'b0; ab2 = 1'b0; din2 = 4'b0000;

    // Reset state
    #1;
    chk1("rst ready", ready0, 1'b1);
    chk1("rst busy", busy0, 1'b0);
    chk1("rst done", done0, 1'b0);
    chk1("rst shr", shr0, 1'b0);
    chk1("rst shr_in", shin0, 1'b0);
    chk4("rst result", res0, 4'b0000);
    chk1("rst match", match0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic GAP=0 transfer
    run0(4'b1011, 4'b1011, 1'b1, "t1");

    // GAP=2 transfer
    run2(4'b0110, 4'b0110, 1'b1, "t2");

    // Bit 2 stuck at 0 in the attached register
    stuck0 = 1'b1;
    run0(4'b0100, 4'b0000, 1'b0, "t3");
    stuck0 = 1'b0;

    // Back-to-back with start_valid held high
    ndone = 0;
    sv0  = 1'b1;
    din0 = 4'b1111;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (done0) ndone++;
      if (c <= 5) chk1($sformatf("t4 c%0d ready", c), ready0, 1'b0);
      if (c == 6) begin
        chk1("t4 c6 ready", ready0, 1'b1);
        chk1("t4 c6 done", done0, 1'b1);
        chk4("t4 c6 result", res0, 4'b1111);
        chk1("t4 c6 match", match0, 1'b1);
      end
      if (c == 7) begin
        chk1("t4 c7 busy", busy0, 1'b1);
        chk1("t4 c7 done", done0, 1'b0);
        chk1("t4 c7 shr", shr0, 1'b1);
        chk1("t4 c7 shr_in", shin0, 1'b1);
      end
      if (c == 12) begin
        chk1("t4 c12 done", done0, 1'b1);
        chk4("t4 c12 result", res0, 4'b0001);
        chk1("t4 c12 match", match0, 1'b1);
      end
      if (c == 1) din0 = 4'b0001;
      if (c == 7) sv0 = 1'b0;
    end
    chk4("t4 done count", 4'(ndone), 4'd2);

    // Abort in cycle 2 of a GAP=0 transfer
    sv0  = 1'b1;
    din0 = 4'b1010;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) sv0 = 1'b0;
      if (c == 2) begin
        chk1("t5 c2 shr", shr0, 1'b1);
        chk1("t5 c2 busy", busy0, 1'b1);
        ab0 = 1'b1;
      end
      if (c == 3) begin
        ab0 = 1'b0;
        chk1("t5 c3 shr", shr0, 1'b0);
        chk1("t5 c3 busy", busy0, 1'b0);
        chk1("t5 c3 ready", ready0, 1'b1);
      end
      if (c >= 3) chk1($sformatf("t5 c%0d done", c), done0, 1'b0);
    end
    chk4("t5 result held", res0, 4'b0001);
    chk1("t5 match held", match0, 1'b1);

    // Asynchronous reset during GAP, then a fresh transfer
    sv2  = 1'b1;
    din2 = 4'b1001;
    @(posedge clk); #1;
    sv2 = 1'b0;
    @(posedge clk); #1;
    chk1("t6 in gap busy", busy2, 1'b1);
    chk1("t6 in gap shr", shr2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("t6 rst busy", busy2, 1'b0);
    chk1("t6 rst ready", ready2, 1'b1);
    chk1("t6 rst shr", shr2, 1'b0);
    chk1("t6 rst shr_in", shin2, 1'b0);
    chk1("t6 rst done", done2, 1'b0);
    chk4("t6 rst result", res2, 4'b0000);
    chk1("t6 rst match", match2, 1'b0);
    #2 rst = 1'b0;
    run2(4'b1001, 4'b1001, 1'b1, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
